fp_pack: RTL and testbench

// - Inverse of the FP unpack/classify stage: takes sign, unbiased signed exponent and wide significand from an

---
 rtl/fp_pack.sv | 244 ++++++++++++++++++++++++
 tb/tb_fp_pack.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_pack.sv
// Iterative IEEE 754 packer: normalize, denormalize, round-to-nearest-even, pack.
// Optional `FP_PACK_FLAGS_EN adds the registered {overflow, underflow, inexact} port.
module fp_pack #(
    parameter int NEXP = 5,
    parameter int NSIG = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [NEXP+1:0]      in_exp,
    input  logic [NSIG+3:0]      in_sig,
    input  logic                 in_nan,
    input  logic                 in_inf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NEXP+NSIG:0]   out_data
`ifdef FP_PACK_FLAGS_EN
    ,
    output logic [2:0]           out_flags
`endif
);

    localparam int BIAS = (1 << (NEXP - 1)) - 1;
    localparam int EMAX = BIAS;
    localparam int EMIN = 1 - BIAS;
    localparam int NW   = NSIG + 4;
    localparam int SA_W = $clog2(NW);
    localparam int EW   = NEXP + 3;
    localparam int ST_W = (SA_W > 1) ? $clog2(SA_W) : 1;
    localparam int DC_W = $clog2(NW);
    localparam int OW   = NEXP + NSIG + 1;

    localparam logic signed [EW-1:0] EMIN_E = EW'(EMIN);
    localparam logic signed [EW-1:0] EMAX_E = EW'(EMAX);
    localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_DENORM,
        S_ROUND,
        S_OUT
    } state_t;

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic signed [EW-1:0]   exp_q, exp_d;
    logic [NW-1:0]          sig_q, sig_d;
    logic [ST_W-1:0]        stage_q, stage_d;
    logic [DC_W-1:0]        dcnt_q, dcnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [OW-1:0]          out_data_q, out_data_d;
`ifdef FP_PACK_FLAGS_EN
    logic                   tiny_q, tiny_d;
    logic [2:0]             out_flags_q, out_flags_d;
`endif

    // Normalize stage: shift by 2^stage when that many leading bits are zero.
    logic [SA_W:0]          norm_amt;
    logic                   norm_top_zero;
    logic [NW-1:0]          norm_sig;
    logic signed [EW-1:0]   norm_exp;

    always_comb begin
        norm_amt      = {{SA_W{1'b0}}, 1'b1} << stage_q;
        norm_top_zero = (sig_q & ~({NW{1'b1}} >> norm_amt)) == '0;
        norm_sig      = norm_top_zero ? (sig_q << norm_amt) : sig_q;
        norm_exp      = norm_top_zero ? (exp_q - EW'(norm_amt)) : exp_q;
    end

    logic [NW-1:0]          dn_sig;
    logic signed [EW-1:0]   dn_exp;

    always_comb begin
        dn_sig = {1'b0, sig_q[NW-1:2], sig_q[1] | sig_q[0]};
        dn_exp = exp_q + EW'(1);
    end

    // Round-to-nearest-even on {lsb, guard, round|sticky}; a carry renormalizes by one.
    logic                   rnd_inc;
    logic [NSIG+1:0]        rnd_m;
    logic                   rnd_carry;
    logic                   rnd_hidden;
    logic [NSIG-1:0]        rnd_frac;
    logic signed [EW-1:0]   rnd_exp;
    logic                   rnd_ovf;
    logic [NEXP-1:0]        rnd_field;

    always_comb begin
        rnd_inc    = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);
        rnd_m      = {1'b0, sig_q[NW-1:3]} + (NSIG+2)'(rnd_inc);
        rnd_carry  = rnd_m[NSIG+1];
        rnd_hidden = rnd_carry | rnd_m[NSIG];
        rnd_frac   = rnd_carry ? rnd_m[NSIG:1] : rnd_m[NSIG-1:0];
        rnd_exp    = exp_q + EW'(rnd_carry);
        rnd_ovf    = rnd_exp > EMAX_E;
        rnd_field  = rnd_hidden ? NEXP'(rnd_exp + BIAS_E) : '0;
    end

    always_comb begin
        // NOTE: every _d gets a default here so no path through the case infers a latch.
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        sig_d       = sig_q;
        stage_d     = stage_q;
        dcnt_d      = dcnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef FP_PACK_FLAGS_EN
        tiny_d      = tiny_q;
        out_flags_d = out_flags_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = {in_exp[NEXP+1], in_exp};
                    sig_d   = in_sig;
                    stage_d = ST_W'(SA_W - 1);
                    dcnt_d  = '0;
`ifdef FP_PACK_FLAGS_EN
                    tiny_d      = 1'b0;
                    out_flags_d = 3'b000;
`endif
                    if (in_nan) begin
                        out_data_d  = {in_sign, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
                        out_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end else if (in_inf) begin
                        out_data_d  = {in_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
                        out_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end else if (in_sig == '0) begin
                        out_data_d  = {in_sign, {(OW-1){1'b0}}};
                        out_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end else begin
                        state_d = S_NORM;
                    end
                end
            end

            S_NORM: begin
                sig_d = norm_sig;
                exp_d = norm_exp;
                if (stage_q == '0) begin
                    if (norm_exp < EMIN_E) begin
                        state_d = S_DENORM;
`ifdef FP_PACK_FLAGS_EN
                        tiny_d  = 1'b1;
`endif
                    end else begin
                        state_d = S_ROUND;
                    end
                end else begin
                    stage_d = stage_q - ST_W'(1);
                end
            end

            S_DENORM: begin
                sig_d  = dn_sig;
                exp_d  = dn_exp;
                dcnt_d = dcnt_q + DC_W'(1);
                // After NW shifts every original bit sits in the sticky position.
                if (dcnt_q == DC_W'(NW - 1)) begin
                    exp_d   = EMIN_E;
                    state_d = S_ROUND;
                end else if (dn_exp >= EMIN_E) begin
                    state_d = S_ROUND;
                end
            end

            S_ROUND: begin
                if (rnd_ovf) begin
                    out_data_d = {sign_q, {NEXP{1'b1}}, {NSIG{1'b0}}};
                end else begin
                    out_data_d = {sign_q, rnd_field, rnd_frac};
                end
`ifdef FP_PACK_FLAGS_EN
                out_flags_d[2] = rnd_ovf;
                out_flags_d[0] = sig_q[2] | sig_q[1] | sig_q[0] | rnd_ovf;
                out_flags_d[1] = tiny_q & out_flags_d[0];
`endif
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end

            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            sig_q       <= '0;
            stage_q     <= '0;
            dcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef FP_PACK_FLAGS_EN
            tiny_q      <= 1'b0;
            out_flags_q <= 3'b000;
`endif
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            sig_q       <= sig_d;
            stage_q     <= stage_d;
            dcnt_q      <= dcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef FP_PACK_FLAGS_EN
            tiny_q      <= tiny_d;
            out_flags_q <= out_flags_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef FP_PACK_FLAGS_EN
    assign out_flags = out_flags_q;
`endif

endmodule

// File: tb/tb_fp_pack.sv
// Directed bench for fp_pack (NEXP=5, NSIG=10): vector table plus handshake and reset sequences.
// Flag expectations are compared when FP_PACK_FLAGS_EN is defined.
module tb_fp_pack;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [6:0]  in_exp;
    logic [13:0] in_sig;
    logic        in_nan;
    logic        in_inf;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
`ifdef FP_PACK_FLAGS_EN
    logic [2:0]  out_flags;
`endif

    int checks = 0;
    int errors = 0;

    fp_pack #(.NEXP(5), .NSIG(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_sig    (in_sig),
        .in_nan    (in_nan),
        .in_inf    (in_inf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FP_PACK_FLAGS_EN
        ,
        .out_flags (out_flags)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        nan;
        logic        inf;
        logic        sign;
        logic [6:0]  e;
        logic [13:0] sig;
        logic [15:0] data;
        logic [2:0]  flags;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_nan  = v.nan;
        in_inf  = v.inf;
        in_sign = v.sign;
        in_exp  = v.e;
        in_sig  = v.sig;
    endtask

    // Accept one input, wait for the result, compare latency and payload, then drain it.
    task automatic run_vec(input vec_t v, input int idx);
        int edges;
        @(negedge clk);
        drive(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check($sformatf("v%0d_latency", idx), edges, v.lat);
        check($sformatf("v%0d_data", idx), out_data, v.data);
`ifdef FP_PACK_FLAGS_EN
        check($sformatf("v%0d_flags", idx), out_flags, v.flags);
`endif
        check($sformatf("v%0d_in_ready_busy", idx), in_ready, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check($sformatf("v%0d_drained", idx), {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        int     edges;
        logic   seen;
        logic [15:0] held;

        //            nan  inf  sgn  exp         sig       data      flags   lat
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 7'(0),    14'h2000, 16'h3C00, 3'b000, 6};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 7'(0),    14'h200C, 16'h3C02, 3'b001, 6};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 7'(0),    14'h2004, 16'h3C00, 3'b001, 6};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 7'(16),   14'h2000, 16'h7C00, 3'b101, 6};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 7'(15),   14'h3FFC, 16'h7C00, 3'b101, 6};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 7'(5),    14'h0008, 16'h2800, 3'b000, 6};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 7'(-15),  14'h2000, 16'h0200, 3'b000, 7};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 7'(-24),  14'h2000, 16'h0001, 3'b000, 16};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 7'(-25),  14'h2000, 16'h0000, 3'b011, 17};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 7'(3),    14'h1234, 16'hFE00, 3'b000, 1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 7'(7),    14'h0000, 16'h8000, 3'b000, 1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 7'(2),    14'h2000, 16'h7C00, 3'b000, 1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 7'(0),    14'h2000, 16'h7E00, 3'b000, 1};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 7'(1),    14'h3000, 16'hC200, 3'b000, 6};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 7'(-15),  14'h3FFC, 16'h0400, 3'b011, 7};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 7'(-64),  14'h2000, 16'h0000, 3'b011, 20};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, 16'h0000);
`ifdef FP_PACK_FLAGS_EN
        check("reset_out_flags", out_flags, 3'b000);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Back-pressure: result must hold while out_ready is low and new input is ignored.
        @(negedge clk);
        drive(vecs[1]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("hold_first_data", out_data, 16'h3C02);
        held = 16'h3C02;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(vecs[9]);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_state", c), {out_valid, in_ready}, 2'b10);
            check($sformatf("hold%0d_data", c), out_data, held);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold_release", {out_valid, in_ready}, 2'b01);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("hold_no_stray_accept", seen, 1'b0);

        // Reset while in NORM: no result may emerge, engine returns to IDLE.
        @(negedge clk);
        drive(vecs[0]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1'b1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_pulse", seen, 1'b0);
        run_vec(vecs[1], 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
